// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus launch sequencer feeding an 8-bit UART transmitter
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int GAP_CYCLES = 2,
  parameter int START_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_err,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              timeout_err,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_done
);
  localparam int LW = ADDR_W + 1;
  localparam int TW = START_TIMEOUT > 1 ? $clog2(START_TIMEOUT) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] t_cnt;
  logic [GW-1:0] g_cnt;
  logic push, drop, pop, expire;
  logic [LW-1:0] level_nxt;
  always_comb begin
    push = wr_en && !full;
    drop = wr_en && full;
    pop = state == IDLE && !empty && !tx_busy;
    expire = state == LAUNCH && !tx_busy && t_cnt == T_LAST;
    level_nxt = level + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      overflow <= 1'b0;
      timeout_err <= 1'b0;
      tx_start <= 1'b0;
      tx_data <= 8'h00;
      t_cnt <= '0;
      g_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      level <= level_nxt;
      full <= level_nxt == LW'(DEPTH);
      empty <= level_nxt == '0;
      overflow <= drop || (overflow && !clr_err);
      timeout_err <= expire || (timeout_err && !clr_err);
      case (state)
        IDLE:
          if (pop) begin
            tx_data <= mem[rd_ptr];
            tx_start <= 1'b1;
            t_cnt <= '0;
            state <= LAUNCH;
          end
        LAUNCH:
          if (tx_busy) begin
            tx_start <= 1'b0;
            state <= WAIT_DONE;
          end else if (expire) begin
            tx_start <= 1'b0;
            g_cnt <= '0;
            state <= GAP_CYCLES == 0 ? IDLE : GAP;
          end else begin
            t_cnt <= t_cnt + TW'(1);
          end
        WAIT_DONE:
          if (tx_done) begin
            g_cnt <= '0;
            state <= GAP_CYCLES == 0 ? IDLE : GAP;
          end
        GAP:
          if (g_cnt == G_LAST) state <= IDLE;
          else g_cnt <= g_cnt + GW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed self-checking bench for uart_tx_feeder with a small transmitter model
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int GAP_CYCLES = 2;
  localparam int START_TIMEOUT = 64;
  logic clk, rst, wr_en, clr_err, full, empty, overflow, timeout_err, tx_start, tx_busy, tx_done;
  logic [7:0] wr_data, tx_data;
  logic [ADDR_W:0] level;
  int n_chk, n_fail, cyc, m_phase, m_cnt, high_len, last_high_len, launch_cyc, last_done_cyc;
  bit model_on, gap_chk, done_nonempty;
  logic prev_start;
  logic [7:0] rx_q[$];
  typedef struct {
    logic we;
    logic [7:0] wd;
    logic clr;
    logic [ADDR_W:0] lvl;
    logic fl;
    logic em;
    logic ov;
  } vec_t;
  vec_t tbl[21];

  uart_tx_feeder #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .GAP_CYCLES(GAP_CYCLES),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .clr_err(clr_err),
    .full(full),
    .empty(empty),
    .level(level),
    .overflow(overflow),
    .timeout_err(timeout_err),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1;
    wr_en = 0;
    clr_err = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    tx_busy = 0;
    tx_done = 0;
    cyc = 0;
    m_phase = 0;
    m_cnt = 0;
    high_len = 0;
    last_high_len = 0;
    launch_cyc = 0;
    last_done_cyc = 0;
    prev_start = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start && !prev_start) begin
        launch_cyc = cyc;
        if (gap_chk && done_nonempty) chk("launch_gap", cyc - last_done_cyc, GAP_CYCLES + 2);
      end
      if (tx_start) high_len++;
      else if (prev_start) begin
        last_high_len = high_len;
        high_len = 0;
      end
      prev_start = tx_start;
      if (!model_on) begin
        tx_busy = 0;
        tx_done = 0;
        m_phase = 0;
      end else begin
        case (m_phase)
          0: if (tx_start) m_phase = 1;
          1: begin
            tx_busy = 1;
            rx_q.push_back(tx_data);
            m_cnt = 0;
            m_phase = 2;
          end
          2: begin
            m_cnt++;
            if (m_cnt == 10) begin
              tx_busy = 0;
              tx_done = 1;
              last_done_cyc = cyc;
              done_nonempty = !empty;
              m_phase = 3;
            end
          end
          default: begin
            tx_done = 0;
            m_phase = 0;
          end
        endcase
      end
    end
  end

  initial begin
    int n;
    logic [7:0] b;
    n_chk = 0;
    n_fail = 0;
    rst = 1;
    wr_en = 0;
    wr_data = 0;
    clr_err = 0;
    model_on = 0;
    gap_chk = 0;
    done_nonempty = 0;
    for (int k = 0; k <= 16; k++)
      tbl[k] = '{1'b1, 8'(16 + k), 1'b0, 5'(k == 0 ? 1 : k), k == 16, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 8'h21, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 8'h22, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    rst = 0;
    for (int i = 0; i < 21; i++) begin
      wr_en = tbl[i].we;
      wr_data = tbl[i].wd;
      clr_err = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("vec%0d_full", i), full, tbl[i].fl);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].em);
      chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].ov);
    end
    wr_en = 0;
    clr_err = 0;
    chk("stall_tx_start", tx_start, 1);
    chk("stall_tx_data", tx_data, 8'h10);
    n = 0;
    while (tx_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_timeout_fell", tx_start, 0);
    repeat (2) @(negedge clk);
    wr_en = 1;
    wr_data = 8'h99;
    @(negedge clk);
    wr_en = 0;
    chk("fullpop_level", level, 15);
    chk("fullpop_overflow", overflow, 1);
    chk("fullpop_full", full, 0);
    chk("fullpop_tx_start", tx_start, 1);
    chk("fullpop_tx_data", tx_data, 8'h11);
    chk("fullpop_timeout_err", timeout_err, 1);

    do_reset();
    wr_en = 1;
    wr_data = 8'h3C;
    @(negedge clk);
    wr_data = 8'h3D;
    @(negedge clk);
    wr_en = 0;
    n = 0;
    while (!tx_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("to_launch_data", tx_data, 8'h3C);
    n = 0;
    while (tx_start && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("to_high_cycles", n, START_TIMEOUT);
    chk("to_err", timeout_err, 1);
    n = 0;
    while (!tx_start && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("to_gap_cycles", n, GAP_CYCLES + 1);
    chk("to_next_data", tx_data, 8'h3D);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    chk("to_err_cleared", timeout_err, 0);

    do_reset();
    model_on = 1;
    rx_q.delete();
    wr_en = 1;
    wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 0;
    chk("single_no_start_yet", tx_start, 0);
    chk("single_level1", level, 1);
    @(negedge clk);
    chk("single_start", tx_start, 1);
    chk("single_data", tx_data, 8'hA5);
    chk("single_empty_after_pop", empty, 1);
    repeat (20) @(negedge clk);
    chk("single_start_len", last_high_len, 2);
    chk("single_rx_count", rx_q.size(), 1);
    b = rx_q.size() > 0 ? rx_q[0] : 8'hxx;
    chk("single_rx_byte", b, 8'hA5);
    chk("single_empty", empty, 1);
    chk("single_idle", tx_start, 0);

    do_reset();
    rx_q.delete();
    done_nonempty = 0;
    gap_chk = 1;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1;
      wr_data = 8'(i);
      @(negedge clk);
      wr_en = 0;
      repeat (4) @(negedge clk);
    end
    n = 0;
    while (rx_q.size() < 20 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("burst_count", rx_q.size(), 20);
    for (int i = 0; i < 20; i++) begin
      b = i < rx_q.size() ? rx_q[i] : 8'hxx;
      chk($sformatf("burst_byte%0d", i), b, 8'(i));
    end
    repeat (30) @(negedge clk);
    gap_chk = 0;
    chk("burst_empty", empty, 1);
    chk("burst_overflow", overflow, 0);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1;
      wr_data = 8'(8'hB0 + i);
      @(negedge clk);
    end
    wr_en = 0;
    n = 0;
    while (!tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("mid_level_before", level, 5);
    chk("mid_start_low", tx_start, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_start", tx_start, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    wr_en = 1;
    wr_data = 8'h77;
    @(negedge clk);
    wr_en = 0;
    chk("mid_level_77", level, 1);
    chk("mid_busy_held", tx_busy, 1);
    chk("mid_no_launch", tx_start, 0);
    n = 0;
    while (!tx_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("mid_launch_after_busy", launch_cyc - last_done_cyc, 1);
    chk("mid_data_77", tx_data, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
